// File: rtl/issue_queue.sv
// In-order issue queue: a circular buffer of decoded instructions whose head is
// offered downstream once every register it touches is clear on the scoreboard.
module issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  input  logic [2:0]  in_sr1,
  input  logic [2:0]  in_sr2,
  input  logic [2:0]  in_dr,
  input  logic        in_sr1_used,
  input  logic        in_sr2_used,
  input  logic        in_dr_used,
  input  logic [7:0]  reg_ready,
  input  logic        exec_ready,
  input  logic        flush,
  output logic        issue_valid,
  output logic [15:0] issue_instr,
  output logic [15:0] issue_pc,
  output logic [2:0]  issue_sr1,
  output logic [2:0]  issue_sr2,
  output logic [2:0]  issue_dr,
  output logic        sb_mark,
  output logic [2:0]  sb_mark_index,
  output logic [15:0] stall_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int EW = 44;

  // Entry layout: {instr, pc, sr1, sr2, dr, sr1_used, sr2_used, dr_used}
  logic [EW-1:0]    entry_mem [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic [15:0]      stall_reg;

  logic [EW-1:0] head_entry;
  logic [EW-1:0] in_entry;
  logic          has_head;
  logic          head_ok;
  logic          enq;
  logic          fire;
  logic          stall_now;

  assign in_entry   = {in_instr, in_pc, in_sr1, in_sr2, in_dr,
                       in_sr1_used, in_sr2_used, in_dr_used};
  assign head_entry = entry_mem[head_reg];
  assign has_head   = (count_reg != '0) && valid_reg[head_reg];

  // Unused source/destination fields never block issue.
  assign head_ok = has_head
                && (!head_entry[2] || reg_ready[head_entry[11:9]])
                && (!head_entry[1] || reg_ready[head_entry[8:6]])
                && (!head_entry[0] || reg_ready[head_entry[5:3]]);

  assign in_ready    = (count_reg < CW'(DEPTH));
  assign enq         = in_valid && in_ready && !flush;
  assign issue_valid = head_ok && !flush && !reset;
  assign fire        = issue_valid && exec_ready;
  assign stall_now   = has_head && !head_ok && !flush;

  assign sb_mark       = fire && head_entry[0];
  assign sb_mark_index = has_head ? head_entry[5:3]   : 3'd0;
  assign issue_instr   = has_head ? head_entry[43:28] : 16'd0;
  assign issue_pc      = has_head ? head_entry[27:12] : 16'd0;
  assign issue_sr1     = has_head ? head_entry[11:9]  : 3'd0;
  assign issue_sr2     = has_head ? head_entry[8:6]   : 3'd0;
  assign issue_dr      = has_head ? head_entry[5:3]   : 3'd0;
  assign stall_count   = stall_reg;

  // Payload storage carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_mem[tail_reg] <= in_entry;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          valid_reg[gi] <= 1'b0;
        end else if (enq && (tail_reg == AW'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end else if (fire && (head_reg == AW'(gi))) begin
          valid_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (enq) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (fire) begin
        head_reg <= head_reg + AW'(1);
      end
      if (enq && !fire) begin
        count_reg <= count_reg + CW'(1);
      end else if (fire && !enq) begin
        count_reg <= count_reg - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (stall_now && (stall_reg != 16'hFFFF)) begin
      stall_reg <= stall_reg + 16'd1;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized and directed checks of issue_queue against a queue-based reference model.
module tb_issue_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr, in_pc;
  logic [2:0]  in_sr1, in_sr2, in_dr;
  logic        in_sr1_used, in_sr2_used, in_dr_used;
  logic [7:0]  reg_ready;
  logic        exec_ready;
  logic        flush;
  logic        issue_valid;
  logic [15:0] issue_instr, issue_pc;
  logic [2:0]  issue_sr1, issue_sr2, issue_dr;
  logic        sb_mark;
  logic [2:0]  sb_mark_index;
  logic [15:0] stall_count;

  issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_sr1_used(in_sr1_used), .in_sr2_used(in_sr2_used), .in_dr_used(in_dr_used),
    .reg_ready(reg_ready), .exec_ready(exec_ready), .flush(flush),
    .issue_valid(issue_valid),
    .issue_instr(issue_instr), .issue_pc(issue_pc),
    .issue_sr1(issue_sr1), .issue_sr2(issue_sr2), .issue_dr(issue_dr),
    .sb_mark(sb_mark), .sb_mark_index(sb_mark_index),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  sr1, sr2, dr;
    logic        u1, u2, ud;
  } ent_t;

  ent_t q[$];
  int   model_stall;
  int   n_checks;
  int   n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_head_ok();
    if (q.size() == 0) return 1'b0;
    return (!q[0].u1 || reg_ready[q[0].sr1])
        && (!q[0].u2 || reg_ready[q[0].sr2])
        && (!q[0].ud || reg_ready[q[0].dr]);
  endfunction

  task automatic drive_idle();
    reset = 0; in_valid = 0; flush = 0; exec_ready = 1; reg_ready = 8'hFF;
    in_instr = 0; in_pc = 0; in_sr1 = 0; in_sr2 = 0; in_dr = 0;
    in_sr1_used = 0; in_sr2_used = 0; in_dr_used = 0;
  endtask

  task automatic drive_instr(input logic [15:0] instr, input logic [15:0] pc,
                             input logic [2:0] s1, input logic u1,
                             input logic [2:0] s2, input logic u2,
                             input logic [2:0] d, input logic ud);
    in_valid = 1; in_instr = instr; in_pc = pc;
    in_sr1 = s1; in_sr1_used = u1; in_sr2 = s2; in_sr2_used = u2;
    in_dr = d; in_dr_used = ud;
  endtask

  // Compare against the model at the falling edge, then advance the model
  // through the rising edge with the inputs currently driven.
  task automatic step(input bit quiet = 0);
    bit   hok, exp_valid, exp_fire, exp_ready;
    ent_t e;
    @(negedge clk);
    hok       = model_head_ok();
    exp_ready = (q.size() < DEPTH);
    exp_valid = hok && !flush && !reset;
    exp_fire  = exp_valid && exec_ready;
    check("in_ready", in_ready, exp_ready);
    check("issue_valid", issue_valid, exp_valid);
    check("sb_mark", sb_mark, exp_fire && q.size() > 0 && q[0].ud);
    check("stall_count", stall_count, model_stall);
    if (!quiet) begin
      if (q.size() > 0) begin
        check("issue_instr", issue_instr, q[0].instr);
        check("issue_pc", issue_pc, q[0].pc);
        check("issue_srcs", {issue_sr1, issue_sr2, issue_dr}, {q[0].sr1, q[0].sr2, q[0].dr});
        check("sb_mark_index", sb_mark_index, q[0].dr);
      end else begin
        check("issue_empty", {issue_instr, issue_pc}, 32'd0);
      end
      if (exp_fire) $display("issue pc=%04h instr=%04h dr=%0d mark=%0b",
                             q[0].pc, q[0].instr, q[0].dr, q[0].ud);
    end
    if (reset || flush) begin
      q.delete();
      if (reset) model_stall = 0;
    end else begin
      if (q.size() > 0 && !hok && model_stall < 16'hFFFF) model_stall++;
      if (exp_fire) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        e.instr = in_instr; e.pc = in_pc;
        e.sr1 = in_sr1; e.sr2 = in_sr2; e.dr = in_dr;
        e.u1 = in_sr1_used; e.u2 = in_sr2_used; e.ud = in_dr_used;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    step(); step();
    drive_idle();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; model_stall = 0;
    drive_idle();
    reset = 1;
    @(posedge clk); #1;
    model_stall = 0; q.delete();
    step();
    drive_idle();
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_stall", stall_count, 0);

    // Single ADD R1,R2,R3 issues the cycle after it is accepted.
    drive_instr(16'h1283, 16'h3000, 3'd2, 1, 3'd3, 1, 3'd1, 1);
    #1 check("add_no_bypass", issue_valid, 0);
    step();
    drive_idle();
    #1;
    check("add_valid", issue_valid, 1);
    check("add_mark", sb_mark, 1);
    check("add_mark_idx", sb_mark_index, 1);
    step();
    check("add_empty", issue_valid, 0);
    check("add_empty_ready", in_ready, 1);

    // RAW hazard on R4 for five cycles.
    do_reset();
    reg_ready = 8'hEF;
    drive_instr(16'h5A04, 16'h3010, 3'd4, 1, 3'd0, 0, 3'd0, 0);
    step();
    drive_idle(); reg_ready = 8'hEF;
    for (int i = 0; i < 5; i++) begin
      #1 check("haz_blocked", issue_valid, 0);
      step();
    end
    reg_ready = 8'hFF;
    #1;
    check("haz_stall5", stall_count, 5);
    check("haz_release", issue_valid, 1);
    step();

    // Backpressure: fill, refuse a fifth, then drain in order.
    do_reset();
    exec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_instr(16'h7000 + 16'(i), 16'h0100 + 16'(i), 3'(i), 1, 3'd5, 1, 3'(i + 1), 1);
      step();
    end
    drive_instr(16'h7004, 16'h0104, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    #1 check("full_not_ready", in_ready, 0);
    step();
    check("bp_no_stall", stall_count, 0);
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_valid", issue_valid, 1);
      check("drain_pc", issue_pc, 16'h0100 + 16'(i));
      step();
    end
    check("drain_empty", issue_valid, 0);

    // Full queue: fire and in_valid together, accepted only on the next cycle.
    do_reset();
    exec_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_instr(16'h2000, 16'h0200 + 16'(i), 3'd0, 0, 3'd0, 0, 3'd0, 0);
      step();
    end
    exec_ready = 1;
    drive_instr(16'h2004, 16'h0204, 3'd0, 0, 3'd0, 0, 3'd7, 1);
    #1 check("full_fire_ready", in_ready, 0);
    step();
    exec_ready = 0;
    #1 check("after_fire_ready", in_ready, 1);
    step();
    drive_idle(); exec_ready = 0;
    #1 check("refilled_ready", in_ready, 0);
    step();

    // Flush with three queued and in_valid high.
    do_reset();
    exec_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_instr(16'h4000, 16'h0300 + 16'(i), 3'd0, 0, 3'd0, 0, 3'd2, 1);
      step();
    end
    exec_ready = 1; flush = 1;
    drive_instr(16'h4003, 16'h0303, 3'd0, 0, 3'd0, 0, 3'd0, 0);
    #1;
    check("flush_no_issue", issue_valid, 0);
    check("flush_no_mark", sb_mark, 0);
    step();
    drive_idle();
    #1;
    check("flush_empty", issue_valid, 0);
    check("flush_ready", in_ready, 1);
    step();

    // Reset mid-operation drops entries without a scoreboard mark.
    exec_ready = 0;
    drive_instr(16'h6000, 16'h0400, 3'd0, 0, 3'd0, 0, 3'd3, 1);
    step();
    drive_idle(); reset = 1;
    #1 check("rst_mid_mark", sb_mark, 0);
    step();
    drive_idle();
    #1 check("rst_mid_empty", issue_valid, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 59) == 0);
      exec_ready = ($urandom_range(0, 3) != 0);
      reg_ready  = 8'($urandom) | 8'($urandom);
      in_valid   = ($urandom_range(0, 2) != 0);
      in_instr   = 16'($urandom); in_pc = 16'($urandom);
      in_sr1 = 3'($urandom); in_sr2 = 3'($urandom); in_dr = 3'($urandom);
      in_sr1_used = 1'($urandom); in_sr2_used = 1'($urandom); in_dr_used = 1'($urandom);
      step();
    end

    // Long stall saturates the counter.
    do_reset();
    reg_ready = 8'h00;
    drive_instr(16'h9999, 16'h0500, 3'd6, 1, 3'd0, 0, 3'd0, 0);
    step(1);
    in_valid = 0;
    for (int i = 0; i < 65540; i++) step(1);
    #1 check("stall_saturated", stall_count, 16'hFFFF);
    step(1);
    check("stall_held", stall_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
